uart_rx_frontend: RTL and testbench

- Receives 8N1 serial bytes from the host USB-UART pin and presents each byte as a one-cycle valid strobe to the debug core's message bridge.
- Sits directly upstream of the debug core's byte-parsing logic; the top level wires the board UART input pin to its rx port.
- Synchronises the asynchronous line, rejects glitch start bits, majority-votes each bit at mid-bit, and flags framing errors.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx_frontend.sv | 152 +++++++++++++++
 tb/tb_uart_rx_frontend.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive front end.
//   state_t   : receiver FSM states
//   mid_point : half-bit sample offset for a given clocks-per-baud value
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    function automatic int mid_point(input int clocks_per_baud);
        return clocks_per_baud / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset (both flops load RESET_VALUE)
//   d    in  asynchronous input
//   q    out synchronised output, two cycles behind d
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver front end for the debug core's message bridge.
// Ports:
//   clk              in   system clock
//   rst              in   asynchronous active-high reset
//   rx               in   raw serial line, idle high, asynchronous to clk
//   data_o           out  last received byte (LSB = first data bit)
//   valid_o          out  one-cycle strobe, data_o valid in the same cycle
//   framing_error_o  out  one-cycle strobe, stop bit sampled low
//   busy_o           out  high whenever the receiver is not idle
//
// Handshake: valid_o and framing_error_o are single-cycle strobes with no
// back-pressure; the consumer must take data_o in the cycle valid_o is high.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = 868,
    parameter int VOTE            = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       framing_error_o,
    output logic       busy_o
);

    localparam int CW = $clog2(CLOCKS_PER_BAUD);
    localparam logic [CW-1:0] MID_C  = CW'(mid_point(CLOCKS_PER_BAUD));
    localparam logic [CW-1:0] LAST_C = CW'(CLOCKS_PER_BAUD - 1);
    localparam bit USE_VOTE = (VOTE != 0);

    logic          rx_s;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic [1:0]    votes, votes_n;   // [1] = sample at target-1, [0] = at target
    logic          pend, pend_n;     // decision cycle (target+1) when voting
    logic [7:0]    data_n;
    logic          valid_n, ferr_n;

    logic [CW-1:0] target;
    logic          at_pre, at_target, sample_now, sample_val;

    sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // START samples at half a bit; DATA/STOP one full bit after the previous
    // sample point. The counter is cleared at the sample point itself, so the
    // third vote sample falls at count 0 of the following period and the
    // nominal sample time never drifts.
    assign target    = (state == START) ? MID_C : LAST_C;
    assign at_pre    = (cnt == target - 1'b1);
    assign at_target = (cnt == target);

    always_comb begin
        if (USE_VOTE) begin
            sample_now = pend;
            sample_val = (votes[1] & votes[0]) | (votes[1] & rx_s) | (votes[0] & rx_s);
        end else begin
            sample_now = at_target;
            sample_val = rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            idx             <= '0;
            shift           <= '0;
            votes           <= '0;
            pend            <= 1'b0;
            data_o          <= 8'h00;
            valid_o         <= 1'b0;
            framing_error_o <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            idx             <= idx_n;
            shift           <= shift_n;
            votes           <= votes_n;
            pend            <= pend_n;
            data_o          <= data_n;
            valid_o         <= valid_n;
            framing_error_o <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        votes_n = votes;
        pend_n  = 1'b0;
        data_n  = data_o;
        valid_n = 1'b0;
        ferr_n  = 1'b0;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START, DATA, STOP: begin
                cnt_n = at_target ? '0 : cnt + 1'b1;
                if (at_pre)    votes_n[1] = rx_s;
                if (at_target) votes_n[0] = rx_s;
                pend_n = USE_VOTE && at_target;
                if (sample_now) begin
                    if (state == START) begin
                        if (sample_val) begin
                            state_n = IDLE;          // glitch, not a real start bit
                        end else begin
                            state_n = DATA;
                            idx_n   = '0;
                        end
                    end else if (state == DATA) begin
                        shift_n = {sample_val, shift[7:1]};
                        idx_n   = idx + 1'b1;
                        if (idx == 3'd7) state_n = STOP;
                    end else begin
                        if (sample_val) begin
                            data_n  = shift;
                            valid_n = 1'b1;
                            state_n = IDLE;
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = BREAK;
                        end
                    end
                end
            end
            BREAK: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;    // one error per held-low line
            end
            default: state_n = IDLE;
        endcase

        if (state_n == IDLE || state_n == BREAK) cnt_n = '0;
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
module tb_uart_rx_frontend;

    localparam int CPB = 8;
    localparam int MID = CPB / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data_o;
    logic       valid_o;
    logic       framing_error_o;
    logic       busy_o;

    uart_rx_frontend #(.CLOCKS_PER_BAUD(CPB), .VOTE(1)) dut (
        .clk             (clk),
        .rst             (rst),
        .rx              (rx),
        .data_o          (data_o),
        .valid_o         (valid_o),
        .framing_error_o (framing_error_o),
        .busy_o          (busy_o)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    // bit 8 = framing error expected, bits 7:0 = expected data_o
    logic [8:0] exp_q[$];
    int         vt_q[$];
    logic [7:0] last_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard: every strobe pops one expected entry
    always @(negedge clk) begin
        if (!rst && (valid_o || framing_error_o)) begin
            check("strobe_exclusive", {31'd0, valid_o & framing_error_o}, 32'd0);
            if (exp_q.size() == 0) begin
                check("spurious_strobe", exp_q.size(), 32'd1);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("strobe_kind", {31'd0, framing_error_o}, {31'd0, e[8]});
                check("strobe_data", {24'd0, data_o}, {24'd0, e[7:0]});
            end
            if (valid_o) vt_q.push_back(cyc);
        end
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val, input logic glitch);
        logic [9:0] bits;
        bits = {stop_val, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                // c == 5 lines up with the middle vote sample of every bit
                rx = (glitch && c == 5) ? ~bits[i] : bits[i];
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  {24'd0, data_o},          32'd0);
        check({tag, "_valid"}, {31'd0, valid_o},         32'd0);
        check({tag, "_ferr"},  {31'd0, framing_error_o}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy_o},          32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       glitch;
        int         gap;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] rnd;
        logic       busy_seen;

        rnd = 8'($urandom_range(0, 255));
        vecs[0] = '{data: 8'hA5, glitch: 1'b0, gap: 20, exp_data: 8'hA5};
        vecs[1] = '{data: 8'h00, glitch: 1'b0, gap: 20, exp_data: 8'h00};
        vecs[2] = '{data: 8'hFF, glitch: 1'b0, gap: 0,  exp_data: 8'hFF};
        vecs[3] = '{data: 8'h81, glitch: 1'b1, gap: 20, exp_data: 8'h81};
        vecs[4] = '{data: 8'h3C, glitch: 1'b0, gap: 5,  exp_data: 8'h3C};
        vecs[5] = '{data: rnd,   glitch: 1'b0, gap: 13, exp_data: rnd};

        rst = 1'b1;
        rx  = 1'b1;
        last_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(5);

        // table-driven frames
        vt_q.delete();
        foreach (vecs[k]) begin
            idle(vecs[k].gap);
            exp_q.push_back({1'b0, vecs[k].exp_data});
            last_data = vecs[k].exp_data;
            send_frame(vecs[k].data, 1'b1, vecs[k].glitch);
        end
        idle(3 * CPB);
        check("table_drain", exp_q.size(), 32'd0);
        check("table_valid_count", vt_q.size(), 32'd6);
        if (vt_q.size() >= 3)
            check("back_to_back_spacing", vt_q[2] - vt_q[1], 32'd80);

        // short low pulse: rejected as a glitch start bit
        @(negedge clk); rx = 1'b0;
        @(negedge clk); rx = 1'b0;
        @(negedge clk); rx = 1'b1;
        busy_seen = 1'b0;
        for (int i = 0; i < MID + 3; i++) begin
            @(negedge clk);
            if (busy_o) busy_seen = 1'b1;
        end
        check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
        check("glitch_busy_cleared", {31'd0, busy_o}, 32'd0);
        idle(2 * CPB);
        check("glitch_no_strobe", exp_q.size(), 32'd0);

        // stop bit low, line held low: one framing error, then break
        exp_q.push_back({1'b1, last_data});
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (40) begin
            @(negedge clk);
            rx = 1'b0;
        end
        check("break_busy_held", {31'd0, busy_o}, 32'd1);
        check("break_one_error", exp_q.size(), 32'd0);
        idle(5);
        check("break_busy_released", {31'd0, busy_o}, 32'd0);
        idle(2 * CPB);

        // reset during bit 4 of 8'h55, then a clean 8'h12
        begin
            logic [9:0] bits;
            bits = {1'b1, 8'h55, 1'b0};
            for (int i = 0; i < 5; i++) begin
                for (int c = 0; c < CPB; c++) begin
                    @(negedge clk);
                    rx = bits[i];
                end
            end
            @(negedge clk); rx = 1'b0;   // bit 4 of 8'h55 is 1; stay in frame a bit
            @(negedge clk); rx = 1'b1;
            rst = 1'b1;
            repeat (2) @(negedge clk);
            check_reset_outputs("midframe_reset");
            rx  = 1'b1;
            rst = 1'b0;
        end
        idle(10);
        exp_q.push_back({1'b0, 8'h12});
        send_frame(8'h12, 1'b1, 1'b0);
        idle(3 * CPB);
        check("after_reset_drain", exp_q.size(), 32'd0);
        check("after_reset_data", {24'd0, data_o}, 32'h12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
